// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  localparam int STAT_W = 16;

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/mem_arb_starve.sv
// Winner select between cpu and dma with a starvation counter that forces dma through.
// Latency: grant is combinational from the requests; starve_cnt updates on the clock edge.
// Backpressure: only arbitrates while arb_en is high (arbiter in IDLE).
//
// Ports: clk, reset (sync, active-high); arb_en = arbiter is idle;
//        cpu_req/dma_req = pending requests; gnt_vld/gnt_id = grant this cycle and its winner.
module mem_arb_starve
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic cpu_req,
  input  logic dma_req,
  output logic gnt_vld,
  output logic gnt_id
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;

  // cpu has priority unless dma has waited through STARVE_MAX cpu grants.
  always_comb begin
    gnt_vld = arb_en & (cpu_req | dma_req);
    gnt_id  = (dma_req & (~cpu_req | (starve_cnt == SMAX))) ? REQ_DMA : REQ_CPU;
  end

  // Whenever dma_req is high in IDLE a grant is made, so the only way to
  // count up is a cpu grant that leaves dma waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (!dma_req || gnt_id == REQ_DMA) begin
        starve_cnt <= '0;
      end else if (starve_cnt != SMAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between cpu (requester 0) and dma (requester 1) with a latency-counted FSM.
// Latency: request seen in IDLE at t -> strobes t+1..t+MEM_LAT -> one-cycle ack at t+MEM_LAT+1.
// Backpressure: requester holds req until ack; cpu_stall/dma_stall = req & ~ack; loser stays pending.
//
// Ports: clk, reset (sync, active-high); cpu_*/dma_* request, write enable, address, write data,
//        read data and ack per requester; mem_rd/mem_wr/mem_addr/mem_wdata/mem_rdata to memory;
//        busy = FSM not idle. Define MEM_ARB_STATS_EN to add saturating stat_* grant/conflict counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              dma_stall,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_cpu_grants,
  output logic [STAT_W-1:0] stat_dma_grants,
  output logic [STAT_W-1:0] stat_conflicts
`endif
);

  localparam int LW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);

  arb_state_t    state;
  logic [LW-1:0] lat_cnt;
  logic          we_l;
  logic          id_l;
  logic          idle;
  logic          gnt_vld;
  logic          gnt_id;

  assign idle = (state == IDLE);

  mem_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .arb_en  (idle),
    .cpu_req (cpu_req),
    .dma_req (dma_req),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  // mem_addr/mem_wdata double as the latched copy of the winner's request,
  // so later changes on the requester side cannot disturb an access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      we_l      <= 1'b0;
      id_l      <= REQ_CPU;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            id_l      <= gnt_id;
            we_l      <= (gnt_id == REQ_DMA) ? dma_we    : cpu_we;
            mem_addr  <= (gnt_id == REQ_DMA) ? dma_addr  : cpu_addr;
            mem_wdata <= (gnt_id == REQ_DMA) ? dma_wdata : cpu_wdata;
            lat_cnt   <= LW'(MEM_LAT - 1);
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_cnt == '0) begin
            if (!we_l) begin
              if (id_l == REQ_DMA) dma_rdata <= mem_rdata;
              else                 cpu_rdata <= mem_rdata;
            end
            state <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_rd    = (state == ACCESS) & ~we_l;
  assign mem_wr    = (state == ACCESS) &  we_l;
  assign cpu_ack   = (state == RESP) & (id_l == REQ_CPU);
  assign dma_ack   = (state == RESP) & (id_l == REQ_DMA);
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign dma_stall = dma_req & ~dma_ack;
  assign busy      = ~idle;

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cpu_grants <= '0;
      stat_dma_grants <= '0;
      stat_conflicts  <= '0;
    end else begin
      if (gnt_vld && gnt_id == REQ_CPU) stat_cpu_grants <= sat_inc(stat_cpu_grants);
      if (gnt_vld && gnt_id == REQ_DMA) stat_dma_grants <= sat_inc(stat_dma_grants);
      if (idle && cpu_req && dma_req)   stat_conflicts  <= sat_inc(stat_conflicts);
    end
  end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between the multicycle CPU controller path (requester 0, "cpu") and an auxiliary loader/DMA engine (requester 1, "dma").
- Sequences each access through a latency-counted FSM and returns a one-cycle ack with captured read data.
- Sits between the CPU datapath memory mux (the IorD-selected address) and the memory model.
- The CPU sees a stall while its request is pending.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, memory access cycles; legal range ≥1
- STARVE_MAX, 4, consecutive cpu grants tolerated while dma_req is pending before dma is forced

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  cpu access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  cpu address
- cpu_wdata  in  DATA_W  cpu write data
- cpu_rdata  out  DATA_W  cpu read data; valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
- dma_req / dma_we / dma_addr / dma_wdata / dma_rdata / dma_ack  same as cpu_*, for requester 1
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  ADDR_W  latched access address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  memory read data; valid in the last ACCESS cycle
- busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port reset.
- Reset values: FSM=IDLE; lat_cnt=0; starve_cnt=0; all acks, mem_rd, mem_wr and busy = 0; cpu_rdata, dma_rdata, mem_addr and mem_wdata = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise select a winner and latch its addr, wdata, we and id into internal registers.
  - Load lat_cnt = MEM_LAT-1, then go to ACCESS.
- Arbitration:
  - cpu wins by default.
  - dma wins if only dma_req is high, or if both are high and starve_cnt == STARVE_MAX.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each cpu grant made while dma_req is high.
  - Clears on a dma grant, or in any IDLE cycle with dma_req low.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latched registers.
  - mem_rd = ~we_l, mem_wr = we_l; both held for all MEM_LAT cycles.
  - lat_cnt decrements each cycle.
  - When lat_cnt == 0: capture mem_rdata into the winner's rdata register (reads only), then go to RESP.
- RESP:
  - Winner's ack = 1 for exactly this one cycle; mem_rd and mem_wr are 0. Next state is IDLE.
  - Requests are ignored in RESP. A requester may keep req high to issue a back-to-back access, which is arbitrated in the following IDLE cycle.
- Latency: request sampled in IDLE at cycle t → ACCESS in cycles t+1 .. t+MEM_LAT → ack at cycle t+MEM_LAT+1.
  - With MEM_LAT=1, minimum turnaround is 3 cycles per access.
- rdata registers:
  - Hold their value until the next read ack to the same requester.
  - Writes never modify rdata.
- Request changes: address or data changes after the grant are ignored, because the latched copy is used.
- Dropped request: if a requester drops req before its ack, the access still completes and the ack still pulses. This is a requester protocol violation, but it is harmless.
- Simultaneous requests: exactly one grant per IDLE cycle. The loser stays pending, and its stall/req persists.
- Reset mid-ACCESS: on the next edge, return to IDLE with strobes deasserted. A partially performed write is not guaranteed; no ack is issued.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - Adds output ports stat_cpu_grants [15:0], stat_dma_grants [15:0] and stat_conflicts [15:0].
  - All three are saturating counters, cleared by reset.
  - Grant counters increment per grant. stat_conflicts increments on each IDLE cycle where both requests are high.
- Undefined: the ports and counters are absent. Functional behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, ACCESS, RESP}
  - requester id constants REQ_CPU=1'b0, REQ_DMA=1'b1
  - stats counter width constant STAT_W=16
- One sub-module, mem_arb_starve: the starve_cnt counter plus winner-select logic. It outputs a grant id and a grant-valid signal.

Test Plan:
- Single cpu read, MEM_LAT=1, mem_rdata=32'hDEADBEEF: cpu_req at t → mem_rd in t+1, cpu_ack and cpu_rdata=32'hDEADBEEF at t+2, busy low at t+3.
- dma write, MEM_LAT=3, addr 0x40, data 0x1234: mem_wr high for exactly 3 cycles with mem_addr=0x40 and mem_wdata=0x1234; dma_ack at t+4; dma_rdata unchanged.
- Both requests held continuously, STARVE_MAX=4: grant order cpu, cpu, cpu, cpu, dma, cpu, ...; cpu_stall high in every non-ack cycle.
- cpu_addr changed to 0x99 during ACCESS after a grant at 0x10: mem_addr stays 0x10 until RESP.
- reset asserted in the second ACCESS cycle (MEM_LAT=3): next cycle FSM=IDLE, mem_wr=0, no ack, starve_cnt=0.
- With MEM_ARB_STATS_EN, 10 cycles of contention: stat_conflicts equals the number of IDLE cycles with both requests high; stat_cpu_grants + stat_dma_grants equals the total number of acks.
